uart_rx: RTL and testbench

UART serial receiver feeding the operand/opcode interface stage of the UART-ALU datapath. Oversamples the asynchronous serial line at 16x the baud rate using a tick from the baud-rate generator. Deserialises one start bit, SIZEDATA data bits (LSB first) and a stop period. Presents each received byte with a one-cycle done strobe and a frame-error flag; the interface stage sequences these bytes into operand A, operand B and opcode.

---
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver for the UART-ALU datapath.
// Receives one start bit, SIZEDATA data bits (LSB first) and a stop period of
// SB_TICK ticks, then presents the byte with a one-cycle done strobe.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_tick         16x-baud sample strike, one i_clk cycle wide
//   i_rx           serial line, asynchronous, idle high
//   o_data         last received byte, held until the next frame completes
//   o_rx_done      one-cycle strobe when o_data/o_frame_error update
//   o_frame_error  stop sample of the last frame was low
module uart_rx #(
    parameter int unsigned SIZEDATA = 8,
    parameter int unsigned SB_TICK  = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_tick,
    input  logic                i_rx,
    output logic [SIZEDATA-1:0] o_data,
    output logic                o_rx_done,
    output logic                o_frame_error
);

    localparam int unsigned SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int unsigned NW = ($clog2(SIZEDATA) > 1) ? $clog2(SIZEDATA) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_sync1;
    logic                r_rx_s;
    logic [SW-1:0]       r_s;
    logic [SW-1:0]       w_s_next;
    logic [NW-1:0]       r_n;
    logic [NW-1:0]       w_n_next;
    logic [SIZEDATA-1:0] r_b;
    logic [SIZEDATA-1:0] w_b_next;
    logic [SIZEDATA-1:0] r_data;
    logic [SIZEDATA-1:0] w_data_next;
    logic                r_done;
    logic                w_done_next;
    logic                r_ferr;
    logic                w_ferr_next;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_rx_s  <= r_sync1;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
            r_data  <= w_data_next;
            r_done  <= w_done_next;
            r_ferr  <= w_ferr_next;
        end
    end

    // Next-state logic; counters only advance on a tick, except start detection.
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_data_next  = r_data;
        w_ferr_next  = r_ferr;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_s_next = '0;
                w_n_next = '0;
                if (!r_rx_s) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (r_s == SW'(7)) begin
                        // Mid start bit: a high line here was a glitch.
                        w_s_next = '0;
                        w_n_next = '0;
                        w_state_next = r_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        w_s_next = r_s + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (r_s == SW'(15)) begin
                        w_s_next = '0;
                        w_b_next = {r_rx_s, r_b[SIZEDATA-1:1]};
                        if (r_n == NW'(SIZEDATA - 1)) begin
                            w_state_next = ST_STOP;
                        end else begin
                            w_n_next = r_n + NW'(1);
                        end
                    end else begin
                        w_s_next = r_s + SW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (i_tick) begin
                    if (r_s == SW'(SB_TICK - 1)) begin
                        w_s_next     = '0;
                        w_data_next  = r_b;
                        w_ferr_next  = ~r_rx_s;
                        w_done_next  = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_s_next = r_s + SW'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_data        = r_data;
    assign o_rx_done     = r_done;
    assign o_frame_error = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed bench for uart_rx.
// Expected frames are derived from the bytes and stop levels the bench sends;
// one compare process checks the DUT outputs on every clock.
module tb_uart_rx;

    localparam int unsigned SIZEDATA = 8;
    localparam int unsigned SB_TICK  = 16;
    localparam int          BIT_CLKS = 64;
    // Strobe window (clocks after the start-bit fall): 2 sync + 1 detect,
    // up to one tick of phase, then 8+16*8+16 ticks of 4 clocks.
    localparam int          LAT_MIN  = 604;
    localparam int          LAT_MAX  = 616;
    localparam int          MAXF     = 128;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic                tick  = 1'b0;
    logic                rx    = 1'b1;
    logic [SIZEDATA-1:0] o_data;
    logic                o_rx_done;
    logic                o_frame_error;

    int cyc = 0;

    // Expected frames, written only by the stimulus process.
    logic [7:0] exp_data  [0:MAXF-1];
    logic       exp_ferr  [0:MAXF-1];
    int         exp_start [0:MAXF-1];
    int         n_sent = 0;

    // Literal pins, handed to the compare process via a sequence number.
    int         lit_seq = 0;
    logic [7:0] lit_data;
    logic       lit_ferr;
    string      lit_name;

    // Owned by the compare process.
    int         n_recv   = 0;
    int         lit_seen = 0;
    int         n_vec    = 0;
    int         n_err    = 0;
    logic [7:0] held_data = 8'h00;
    logic       held_ferr = 1'b0;

    uart_rx #(.SIZEDATA(SIZEDATA), .SB_TICK(SB_TICK)) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_tick        (tick),
        .i_rx          (rx),
        .o_data        (o_data),
        .o_rx_done     (o_rx_done),
        .o_frame_error (o_frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One tick every 4 clocks.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick = ((cyc % 4) == 0);
        end
    end

    // Compare process: outputs checked every cycle at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_vec++;
            if (o_rx_done !== 1'b0 || o_data !== 8'h00 || o_frame_error !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state: got data=%h done=%b ferr=%b want 00/0/0",
                         o_data, o_rx_done, o_frame_error);
            end
            held_data = 8'h00;
            held_ferr = 1'b0;
        end else begin
            if (n_recv < n_sent && cyc > exp_start[n_recv] + LAT_MAX) begin
                n_vec++;
                n_err++;
                $display("FAIL strobe_timeout: frame %0d data %h never strobed by cycle %0d",
                         n_recv, exp_data[n_recv], cyc);
                n_recv++;
            end
            n_vec++;
            if (o_rx_done === 1'b1) begin
                if (n_recv >= n_sent) begin
                    n_err++;
                    $display("FAIL spurious_strobe: got strobe data=%h at cycle %0d, want no strobe",
                             o_data, cyc);
                end else begin
                    if (cyc < exp_start[n_recv] + LAT_MIN || cyc > exp_start[n_recv] + LAT_MAX) begin
                        n_err++;
                        $display("FAIL strobe_time: got latency %0d want %0d..%0d",
                                 cyc - exp_start[n_recv], LAT_MIN, LAT_MAX);
                    end
                    if (o_data !== exp_data[n_recv] || o_frame_error !== exp_ferr[n_recv]) begin
                        n_err++;
                        $display("FAIL frame_%0d: got data=%h ferr=%b want data=%h ferr=%b",
                                 n_recv, o_data, o_frame_error, exp_data[n_recv], exp_ferr[n_recv]);
                    end
                    held_data = exp_data[n_recv];
                    held_ferr = exp_ferr[n_recv];
                    n_recv++;
                end
            end else if (o_rx_done !== 1'b0) begin
                n_err++;
                $display("FAIL done_x: got done=%b want 0 or 1", o_rx_done);
            end else if (o_data !== held_data || o_frame_error !== held_ferr) begin
                n_err++;
                $display("FAIL hold: got data=%h ferr=%b want data=%h ferr=%b at cycle %0d",
                         o_data, o_frame_error, held_data, held_ferr, cyc);
            end
        end
        if (lit_seq != lit_seen) begin
            lit_seen = lit_seq;
            n_vec++;
            if (o_data !== lit_data || o_frame_error !== lit_ferr) begin
                n_err++;
                $display("FAIL lit_%s: got data=%h ferr=%b want data=%h ferr=%b",
                         lit_name, o_data, o_frame_error, lit_data, lit_ferr);
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input logic [7:0] d, input logic fe);
        lit_name = name;
        lit_data = d;
        lit_ferr = fe;
        lit_seq++;
        wait_clks(2);
    endtask

    // A bad stop is held low over the sample point only, then released.
    task automatic send_frame(input logic [7:0] d, input bit good_stop);
        exp_data[n_sent]  = d;
        exp_ferr[n_sent]  = ~good_stop;
        exp_start[n_sent] = cyc;
        n_sent++;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int k = 0; k < 8; k++) begin
            rx = d[k];
            wait_clks(BIT_CLKS);
        end
        if (good_stop) begin
            rx = 1'b1;
            wait_clks(BIT_CLKS);
        end else begin
            rx = 1'b0;
            wait_clks(48);
            rx = 1'b1;
            wait_clks(16);
        end
    endtask

    task automatic glitch(input int clks);
        rx = 1'b0;
        wait_clks(clks);
        rx = 1'b1;
        wait_clks(100);
    endtask

    initial begin
        logic [7:0] c3;
        logic [7:0] rd;
        bit         good;
        c3 = 8'hC3;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(20);
        pin("reset", 8'h00, 1'b0);

        // Single frame
        send_frame(8'h55, 1'b1);
        pin("single_55", 8'h55, 1'b0);
        wait_clks(150);
        pin("single_55_hold", 8'h55, 1'b0);

        // Back-to-back, no idle
        send_frame(8'hA3, 1'b1);
        pin("b2b_a3", 8'hA3, 1'b0);
        send_frame(8'h0F, 1'b1);
        pin("b2b_0f", 8'h0F, 1'b0);
        wait_clks(50);

        // Glitch, then a good frame
        glitch(12);
        pin("after_glitch", 8'h0F, 1'b0);
        send_frame(8'h81, 1'b1);
        pin("frame_81", 8'h81, 1'b0);
        wait_clks(30);

        // Bad stop, then a good frame clears the error
        send_frame(8'hFF, 1'b0);
        pin("bad_stop_ff", 8'hFF, 1'b1);
        wait_clks(80);
        send_frame(8'h12, 1'b1);
        pin("good_12", 8'h12, 1'b0);
        wait_clks(40);

        // Reset during data bit 4 of 0xC3; that frame is never expected
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int k = 0; k < 4; k++) begin
            rx = c3[k];
            wait_clks(BIT_CLKS);
        end
        rx = c3[4];
        wait_clks(32);
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_clks(1);
        pin("in_reset", 8'h00, 1'b0);
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(200);
        send_frame(8'h3C, 1'b1);
        pin("after_reset_3c", 8'h3C, 1'b0);
        wait_clks(20);

        // Operand A, operand B, opcode
        send_frame(8'h05, 1'b1);
        pin("opa_05", 8'h05, 1'b0);
        send_frame(8'hFD, 1'b1);
        pin("opb_fd", 8'hFD, 1'b0);
        send_frame(8'h20, 1'b1);
        pin("op_20", 8'h20, 1'b0);
        wait_clks(40);

        // Randomized frames, stop levels, gaps and glitches
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                glitch(int'($urandom_range(4, 20)));
            end
            rd   = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            send_frame(rd, good);
            if (!good) begin
                wait_clks(int'($urandom_range(64, 120)));
            end else if ($urandom_range(0, 3) != 0) begin
                wait_clks(int'($urandom_range(1, 90)));
            end
        end

        wait_clks(700);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
